// File: rtl/timer_pkg.sv
// Shared constants for the tenth-second timer family: FSM encoding, the
// 25 MHz tenth-second prescale value and the 4-bit count limit.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int unsigned TENTH_TICKS_25MHZ = 2_500_000;
  localparam int unsigned COUNT_W           = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(15);

endpackage

// File: rtl/tenth_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICKS_PER_TENTH
// cycles while enabled; holds its value when disabled.
module tenth_prescaler #(
  parameter int unsigned TICKS_PER_TENTH = 4,
  parameter int unsigned PRESCALE_W      = 22
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_TENTH - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = en_i && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/interval_meter.sv
// Measures arm-to-stop elapsed time in whole tenths of a second, saturating
// at 15, and holds the result with a valid/ack handshake.
module interval_meter
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_TENTH = TENTH_TICKS_25MHZ,
  parameter int unsigned PRESCALE_W      = 22
) (
  input  logic               clock_25mhz,
  input  logic               reset_sync,
  input  logic               arm,
  input  logic               stop,
  input  logic               ack,
  output logic [COUNT_W-1:0] measured,
  output logic               valid,
  output logic               overflow,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   measured_q, measured_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 pre_clr;
  logic                 pre_en;

  // Reset and every arm restart the tenth phase from zero.
  assign pre_clr = reset_sync || arm;
  assign pre_en  = (state_q == MEASURE);

  tenth_prescaler #(
    .TICKS_PER_TENTH (TICKS_PER_TENTH),
    .PRESCALE_W      (PRESCALE_W)
  ) u_prescaler (
    .clk_i  (clock_25mhz),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    measured_d = measured_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = MEASURE;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      MEASURE: begin
        if (arm) begin
          count_d = '0;
        end else if (tick) begin
          // A tick at full count is the unrepresentable 16th tenth.
          if (count_q == COUNT_MAX) begin
            state_d    = DONE;
            measured_d = COUNT_MAX;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + COUNT_W'(1);
            if (stop) begin
              state_d    = DONE;
              measured_d = count_q + COUNT_W'(1);
            end
          end
        end else if (stop) begin
          state_d    = DONE;
          measured_d = count_q;
        end
      end
      DONE: begin
        if (arm) begin
          state_d    = MEASURE;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == MEASURE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock_25mhz) begin
    if (reset_sync) begin
      state_q    <= IDLE;
      count_q    <= '0;
      measured_q <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      measured_q <= measured_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign measured = measured_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter with a four-cycle tenth: arm/stop vector table,
// hand-built corner sequences and a long randomized run against a model.
module tb_interval_meter;

  localparam int unsigned T = 4;

  logic       clk;
  logic       reset_sync, arm, stop, ack;
  logic [3:0] measured;
  logic       valid, overflow, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: elapsed ticks derived from the arm time, not from a counter.
  int         m_mode = 0;  // 0 idle, 1 measuring, 2 done
  int         m_t    = 0;
  int         m_meas = 0;
  int         m_ovf  = 0;

  interval_meter #(.TICKS_PER_TENTH(T), .PRESCALE_W(3)) dut (
    .clock_25mhz (clk),
    .reset_sync  (reset_sync),
    .arm         (arm),
    .stop        (stop),
    .ack         (ack),
    .measured    (measured),
    .valid       (valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit a, input bit s, input bit k, input int c);
    if (r) begin
      m_mode = 0; m_meas = 0; m_ovf = 0;
    end else if (a) begin
      m_mode = 1; m_t = c; m_ovf = 0;
    end else if (m_mode == 1) begin
      if (c - m_t == 16 * int'(T)) begin
        m_mode = 2; m_meas = 15; m_ovf = 1;
      end else if (s) begin
        m_mode = 2; m_meas = (c - m_t) / int'(T);
      end
    end else if (m_mode == 2 && k) begin
      m_mode = 0;
    end
  endtask

  // One clock: drive, model the edge, compare on the falling edge.
  task automatic step(input bit r, input bit a, input bit s, input bit k);
    reset_sync = r; arm = a; stop = s; ack = k;
    @(posedge clk);
    cyc++;
    model_edge(r, a, s, k, cyc);
    @(negedge clk);
    reset_sync = 1'b0; arm = 1'b0; stop = 1'b0; ack = 1'b0;
    chk("model valid",    int'(valid),    (m_mode == 2) ? 1 : 0);
    chk("model busy",     int'(busy),     (m_mode == 1) ? 1 : 0);
    chk("model overflow", int'(overflow), m_ovf);
    chk("model measured", int'(measured), m_meas);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  typedef struct {
    int delay;     // stop edge relative to arm edge
    int exp_meas;
    int exp_ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset_sync = 1'b1; arm = 1'b0; stop = 1'b0; ack = 1'b0;
    vecs.push_back('{13, 3, 0});
    vecs.push_back('{12, 3, 0});
    vecs.push_back('{11, 2, 0});
    vecs.push_back('{3,  0, 0});
    vecs.push_back('{4,  1, 0});
    vecs.push_back('{1,  0, 0});
    vecs.push_back('{63, 15, 0});
    vecs.push_back('{64, 15, 1});

    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset valid",    int'(valid),    0);
    chk("reset busy",     int'(busy),     0);
    chk("reset measured", int'(measured), 0);
    chk("reset overflow", int'(overflow), 0);

    // Table: arm, stop after 'delay' cycles, then acknowledge.
    foreach (vecs[i]) begin
      step(0, 1, 0, 0);
      chk("arm busy", int'(busy), 1);
      idle(vecs[i].delay - 1);
      step(0, 0, 1, 0);
      chk($sformatf("vec%0d valid", i),    int'(valid),    1);
      chk($sformatf("vec%0d busy", i),     int'(busy),     0);
      chk($sformatf("vec%0d measured", i), int'(measured), vecs[i].exp_meas);
      chk($sformatf("vec%0d overflow", i), int'(overflow), vecs[i].exp_ovf);
      step(0, 0, 0, 1);
      chk($sformatf("vec%0d ack valid", i), int'(valid),    0);
      chk($sformatf("vec%0d ack hold", i),  int'(measured), vecs[i].exp_meas);
    end

    // Saturation without stop; a late stop is ignored.
    step(0, 1, 0, 0);
    idle(63);
    chk("sat pre busy",  int'(busy),  1);
    chk("sat pre valid", int'(valid), 0);
    idle(1);
    chk("sat valid",    int'(valid),    1);
    chk("sat measured", int'(measured), 15);
    chk("sat overflow", int'(overflow), 1);
    idle(5);
    step(0, 0, 1, 0);
    chk("sat stop measured", int'(measured), 15);
    chk("sat stop valid",    int'(valid),    1);

    // Arm together with ack leaves DONE for MEASURE.
    step(0, 1, 0, 1);
    chk("arm+ack busy",     int'(busy),     1);
    chk("arm+ack valid",    int'(valid),    0);
    chk("arm+ack overflow", int'(overflow), 0);

    // Re-arm at +9, stop at +18.
    step(0, 1, 0, 0);
    idle(8);
    step(0, 1, 0, 0);
    idle(8);
    step(0, 0, 1, 0);
    chk("rearm measured", int'(measured), 2);
    step(0, 0, 0, 1);

    // Arm and stop on the same edge stays measuring.
    step(0, 1, 0, 0);
    idle(8);
    step(0, 1, 1, 0);
    chk("arm+stop busy",  int'(busy),  1);
    chk("arm+stop valid", int'(valid), 0);
    idle(5);
    step(0, 0, 1, 0);
    chk("arm+stop result", int'(measured), 1);
    step(0, 0, 0, 1);

    // Stop and ack in IDLE change nothing.
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("idle valid",    int'(valid),    0);
    chk("idle busy",     int'(busy),     0);
    chk("idle measured", int'(measured), 1);

    // Reset mid-measurement discards everything.
    step(0, 1, 0, 0);
    idle(6);
    step(1, 0, 0, 0);
    chk("midreset busy",     int'(busy),     0);
    chk("midreset measured", int'(measured), 0);
    step(0, 0, 1, 0);
    chk("postreset valid", int'(valid), 0);
    chk("postreset busy",  int'(busy),  0);

    // Randomized pulses against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 14) == 0,  $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
